// File: rtl/pe8_arbiter.sv
// pe8_arbiter: shares one resource among eight requesters.
// Grants are registered and one-hot, with an encoded id and a valid flag.
// A grant is held until the owner drops its request or MAX_HOLD cycles pass.
// A requester whose grant was revoked stays blocked until it drops its request.
// Optional feature: define PE8_ARB_ROUND_ROBIN_EN to get rotating priority.
// Without it, the arbiter uses fixed priority and the highest index wins.
module pe8_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout,
  output logic [7:0] blocked
);

  localparam int CW = $clog2(MAX_HOLD);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    gnt_id_q, gnt_id_d;
  logic          gnt_valid_q, gnt_valid_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    blocked_q, blocked_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    eligible_s;
  logic [7:0]    block_set_s;
  logic [2:0]    winner_s;

`ifdef PE8_ARB_ROUND_ROBIN_EN
  logic [2:0]    ptr_q, ptr_d;

  // Search ascends from the pointer with wrap-around; the first eligible index wins.
  function automatic logic [2:0] pick_rr(input logic [7:0] e, input logic [2:0] p);
    logic [2:0] r;
    logic [2:0] idx;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (e[idx]) r = idx;
      else        r = r;
    end
    return r;
  endfunction
`else
  // Fixed priority: the highest set index wins.
  function automatic logic [2:0] pick_fixed(input logic [7:0] e);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = 3'(i);
      else      r = r;
    end
    return r;
  endfunction
`endif

  // Winner selection among requesters that are not blocked.
  always_comb begin
    eligible_s = req & ~blocked_q;
`ifdef PE8_ARB_ROUND_ROBIN_EN
    winner_s = pick_rr(eligible_s, ptr_q);
`else
    winner_s = pick_fixed(eligible_s);
`endif
  end

  // Next-state and next-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    cnt_d       = cnt_q;
    block_set_s = 8'h00;
`ifdef PE8_ARB_ROUND_ROBIN_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (|eligible_s) begin
          gnt_d       = 8'h01 << winner_s;
          gnt_id_d    = winner_s;
          gnt_valid_d = 1'b1;
          cnt_d       = {CW{1'b0}};
          state_d     = GRANT;
`ifdef PE8_ARB_ROUND_ROBIN_EN
          ptr_d       = winner_s + 3'd1;
`endif
        end else begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_id_q]) begin
          // Release wins over a coincident timeout: no pulse, no block.
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          cnt_d       = {CW{1'b0}};
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          gnt_d       = 8'h00;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
          block_set_s = gnt_q;
          cnt_d       = {CW{1'b0}};
          state_d     = IDLE;
        end else begin
          cnt_d       = cnt_q + CNT_ONE;
        end
      end
      default: begin
        gnt_d       = 8'h00;
        gnt_valid_d = 1'b0;
        cnt_d       = {CW{1'b0}};
        state_d     = IDLE;
      end
    endcase
    // A blocked bit clears once its request is seen low; a revoke sets it.
    blocked_d = (blocked_q & req) | block_set_s;
  end

  // State and output registers; reset drops all outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 8'h00;
      gnt_id_q    <= 3'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      blocked_q   <= 8'h00;
      cnt_q       <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      blocked_q   <= blocked_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef PE8_ARB_ROUND_ROBIN_EN
  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= 3'd0;
    else     ptr_q <= ptr_d;
  end
`endif

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign blocked   = blocked_q;

endmodule

// File: tb/tb_pe8_arbiter.sv
// Directed bench for pe8_arbiter with MAX_HOLD=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_pe8_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic [7:0] blocked;

  int passed;
  int total;

  pe8_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .blocked   (blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Checks the full output set in one call.
  task automatic chk_all(input string tag, input logic [7:0] e_gnt, input logic [2:0] e_id,
                         input logic e_val, input logic e_to, input logic [7:0] e_blk);
    chk({tag, ".gnt"}, gnt, e_gnt);
    chk({tag, ".gnt_id"}, {5'd0, gnt_id}, {5'd0, e_id});
    chk({tag, ".gnt_valid"}, {7'd0, gnt_valid}, {7'd0, e_val});
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e_to});
    chk({tag, ".blocked"}, blocked, e_blk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b1;
    req = 8'h00;
    tick();
    tick();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    tick();
    chk_all("idle_noreq", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);

    // Single request held for three grant cycles, then dropped.
    req = 8'h04;
    tick();
    chk_all("single_c1", 8'h04, 3'd2, 1'b1, 1'b0, 8'h00);
    tick();
    chk_all("single_c2", 8'h04, 3'd2, 1'b1, 1'b0, 8'h00);
    tick();
    chk_all("single_c3", 8'h04, 3'd2, 1'b1, 1'b0, 8'h00);
    req = 8'h00;
    tick();
    chk_all("single_rel", 8'h00, 3'd2, 1'b0, 1'b0, 8'h00);

`ifndef PE8_ARB_ROUND_ROBIN_EN
    // Fixed priority: bit 4 beats bit 0 on every arbitration.
    req = 8'h11;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk_all("fixed_win", 8'h10, 3'd4, 1'b1, 1'b0, 8'h00);
      req = 8'h01;
      tick();
      chk_all("fixed_rel", 8'h00, 3'd4, 1'b0, 1'b0, 8'h00);
      req = 8'h11;
    end
    req = 8'h00;
    tick();
    chk("fixed_end.gnt", gnt, 8'h00);
`endif

    // Timeout: request held past MAX_HOLD=4 cycles.
    req = 8'h20;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_all("to_hold", 8'h20, 3'd5, 1'b1, 1'b0, 8'h00);
    end
    tick();
    chk_all("to_pulse", 8'h00, 3'd5, 1'b0, 1'b1, 8'h20);
    tick();
    chk_all("to_blocked", 8'h00, 3'd5, 1'b0, 1'b0, 8'h20);
    req = 8'h00;
    tick();
    chk_all("to_unblock", 8'h00, 3'd5, 1'b0, 1'b0, 8'h00);

    // Reassert after unblock: granted again; drop on the final hold cycle.
    req = 8'h20;
    tick();
    chk_all("regrant_c1", 8'h20, 3'd5, 1'b1, 1'b0, 8'h00);
    tick();
    chk_all("regrant_c2", 8'h20, 3'd5, 1'b1, 1'b0, 8'h00);
    tick();
    chk_all("regrant_c3", 8'h20, 3'd5, 1'b1, 1'b0, 8'h00);
    tick();
    chk_all("regrant_c4", 8'h20, 3'd5, 1'b1, 1'b0, 8'h00);
    req = 8'h00;
    tick();
    chk_all("rel_vs_to", 8'h00, 3'd5, 1'b0, 1'b0, 8'h00);
    tick();
    chk_all("rel_vs_to_after", 8'h00, 3'd5, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a grant.
    req = 8'hFF;
    tick();
    chk("midgrant.gnt_valid", {7'd0, gnt_valid}, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 8'h00);
    tick();
    rst = 1'b0;
    tick();
`ifdef PE8_ARB_ROUND_ROBIN_EN
    chk_all("post_rst", 8'h01, 3'd0, 1'b1, 1'b0, 8'h00);
    // Rotating order: each owner holds two cycles, then drops its bit once.
    for (int k = 0; k < 9; k++) begin
      logic [7:0] bit_v;
      bit_v = 8'h01 << (k % 8);
      if (k != 0) begin
        tick();
        chk_all("rr_c1", bit_v, 3'(k % 8), 1'b1, 1'b0, 8'h00);
      end
      tick();
      chk_all("rr_c2", bit_v, 3'(k % 8), 1'b1, 1'b0, 8'h00);
      req = 8'hFF & ~bit_v;
      tick();
      chk_all("rr_idle", 8'h00, 3'(k % 8), 1'b0, 1'b0, 8'h00);
      req = 8'hFF;
    end
`else
    chk_all("post_rst", 8'h80, 3'd7, 1'b1, 1'b0, 8'h00);
`endif
    req = 8'h00;
    tick();
    chk("final.gnt", gnt, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
